// File: rtl/ft_pkg.sv
// ft_pkg
// Shared definitions for the FT232H 245-synchronous-FIFO transmit path.
// Holds the controller state encoding and the FT data bus width, so the
// interface, the holding buffer and the controller all agree on them.
package ft_pkg;

    localparam int FT_DATA_W = 8;

    typedef logic [FT_DATA_W-1:0] ft_byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FLUSH  = 2'd3
    } ft_state_t;

endpackage

// File: rtl/ft_tx_ctrl_if.sv
// ft_tx_ctrl_if
// Bundles the camera FIFO read port and the FT232H bus pins used by
// ft_tx_ctrl.
//   fifo_q        FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdempty  FIFO empty flag
//   fifo_rdusedw  FIFO fill level
//   fifo_rdreq    FIFO read request
//   ft_txe_n      FT TX FIFO has space when low
//   ft_data       FT data bus
//   ft_wr_n       FT write strobe, active low
//   ft_siwu_n     FT send-immediate, active low
//   ft_rd_n       FT read strobe (unused, held high)
//   ft_oe_n       FT output enable (unused, held high)
// master: the transmit controller.  slave: the FIFO + FT chip side.
interface ft_tx_ctrl_if #(
    parameter int ADDR_W = 10
);
    import ft_pkg::*;

    ft_byte_t          fifo_q;
    logic              fifo_rdempty;
    logic [ADDR_W-1:0] fifo_rdusedw;
    logic              fifo_rdreq;
    logic              ft_txe_n;
    ft_byte_t          ft_data;
    logic              ft_wr_n;
    logic              ft_siwu_n;
    logic              ft_rd_n;
    logic              ft_oe_n;

    modport master (
        input  fifo_q, fifo_rdempty, fifo_rdusedw, ft_txe_n,
        output fifo_rdreq, ft_data, ft_wr_n, ft_siwu_n, ft_rd_n, ft_oe_n
    );

    modport slave (
        output fifo_q, fifo_rdempty, fifo_rdusedw, ft_txe_n,
        input  fifo_rdreq, ft_data, ft_wr_n, ft_siwu_n, ft_rd_n, ft_oe_n
    );

endinterface

// File: rtl/ft_skid2.sv
// ft_skid2
// Two-entry ordered holding buffer. The head entry is the FT output
// register itself (head/head_n drive ft_data/ft_wr_n directly), the tail
// entry is the skid register that catches a byte landing while the head is
// stalled by TXE#.
//   clk, rst  clock, asynchronous active-high reset
//   push, din byte landing from the FIFO this cycle
//   pop       head byte accepted by the FT chip this cycle
//   head      current head byte (FT data bus)
//   head_n    head empty flag, i.e. the active-low write strobe
//   occ       number of valid entries (0..2)
module ft_skid2
    import ft_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  ft_byte_t din,
    input  logic     pop,
    output ft_byte_t head,
    output logic     head_n,
    output logic [1:0] occ
);

    ft_byte_t head_q;
    logic     head_n_q;
    ft_byte_t tail_q;
    logic     tail_v;

    ft_byte_t head_d;
    logic     head_v_d;
    ft_byte_t tail_d;
    logic     tail_v_d;

    // Pop first so the tail advances into the head, then let a landing byte
    // take the first free slot. This keeps bytes strictly in arrival order.
    always_comb begin
        head_d   = head_q;
        head_v_d = !head_n_q;
        tail_d   = tail_q;
        tail_v_d = tail_v;

        if (pop && !head_n_q) begin
            head_v_d = tail_v;
            if (tail_v) begin
                head_d = tail_q;
            end
            tail_v_d = 1'b0;
        end

        if (push) begin
            if (!head_v_d) begin
                head_v_d = 1'b1;
                head_d   = din;
            end else begin
                tail_v_d = 1'b1;
                tail_d   = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            head_n_q <= 1'b1;
            tail_q   <= '0;
            tail_v   <= 1'b0;
        end else begin
            head_q   <= head_d;
            head_n_q <= !head_v_d;
            tail_q   <= tail_d;
            tail_v   <= tail_v_d;
        end
    end

    assign head   = head_q;
    assign head_n = head_n_q;
    assign occ    = {1'b0, !head_n_q} + {1'b0, tail_v};

endmodule

// File: rtl/ft_tx_ctrl.sv
// ft_tx_ctrl
// Drains the camera data FIFO and writes bytes to an FT232H in 245
// synchronous FIFO mode, entirely in the 60 MHz FT CLKOUT domain.
// Streaming starts once BURST_MIN bytes are buffered, or after
// FLUSH_CYCLES idle cycles with any data present. After FLUSH_CYCLES idle
// cycles with an empty FIFO and unsent-since-flush data, SIWU# is pulsed
// for one cycle so the FT chip ships its partial packet.
//   clk         FT CLKOUT, the only clock
//   rst         asynchronous active-high reset
//   bus         FIFO read port + FT bus (master modport)
//   bytes_sent  count of bytes accepted by the FT chip, wraps
module ft_tx_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int BURST_MIN    = 64,
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    ft_tx_ctrl_if.master       bus,
    output logic [31:0]        bytes_sent
);

    localparam int                TMR_W     = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(FLUSH_CYCLES);
    localparam logic [ADDR_W-1:0] BURST_LVL = ADDR_W'(BURST_MIN);

    ft_state_t        state;
    ft_state_t        state_next;
    logic             rd_pend;
    logic             dirty;
    logic [TMR_W-1:0] idle_tmr;
    logic             tmr_done;
    logic             siwu_n_q;
    logic [31:0]      sent_cnt;

    logic             acc;
    logic             rdreq;
    logic [1:0]       buf_occ;
    logic [2:0]       occ;
    ft_byte_t         head;
    logic             head_n;

    ft_skid2 u_skid (
        .clk    (clk),
        .rst    (rst),
        .push   (rd_pend),
        .din    (bus.fifo_q),
        .pop    (acc),
        .head   (head),
        .head_n (head_n),
        .occ    (buf_occ)
    );

    // A byte leaves when the strobe is low and the FT chip has room.
    assign acc      = !head_n && !bus.ft_txe_n;
    assign occ      = {1'b0, buf_occ} + {2'b00, rd_pend};
    assign tmr_done = (idle_tmr == TMR_MAX);

    // Read only when the byte can be stored two edges from now: counting the
    // in-flight byte and the one leaving this cycle, at most one slot may be
    // taken. This is what lets a TXE# stall hold at most two bytes.
    assign rdreq = (state == STREAM) && !bus.fifo_rdempty
                   && ((occ - {2'b00, acc}) < 3'd2);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if ((bus.fifo_rdusedw >= BURST_LVL) || (!bus.fifo_rdempty && tmr_done)) begin
                    state_next = STREAM;
                end else if (tmr_done && bus.fifo_rdempty && dirty && (occ == 3'd0)) begin
                    state_next = FLUSH;
                end
            end
            STREAM: begin
                if (bus.fifo_rdempty && !rdreq) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == 3'd0) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_pend  <= 1'b0;
            siwu_n_q <= 1'b1;
        end else begin
            state    <= state_next;
            rd_pend  <= rdreq;
            siwu_n_q <= (state_next != FLUSH);
        end
    end

    // The timer only runs while sitting in IDLE; anything else restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_tmr <= '0;
        end else if ((state != IDLE) || (state_next != IDLE) || acc) begin
            idle_tmr <= '0;
        end else if (!tmr_done) begin
            idle_tmr <= idle_tmr + TMR_W'(1);
        end
    end

    // dirty remembers that bytes went out since the last SIWU# pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty <= 1'b0;
        end else if (acc) begin
            dirty <= 1'b1;
        end else if (state == FLUSH) begin
            dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_cnt <= '0;
        end else if (acc) begin
            sent_cnt <= sent_cnt + 32'd1;
        end
    end

    assign bus.fifo_rdreq = rdreq;
    assign bus.ft_data    = head;
    assign bus.ft_wr_n    = head_n;
    assign bus.ft_siwu_n  = siwu_n_q;
    assign bus.ft_rd_n    = 1'b1;
    assign bus.ft_oe_n    = 1'b1;
    assign bytes_sent     = sent_cnt;

endmodule

// File: tb/tb_ft_tx_ctrl.sv
// tb_ft_tx_ctrl
// Scoreboard bench for ft_tx_ctrl. Bytes written into the FIFO model are
// pushed onto the expected queue in FIFO order; a negedge monitor pops and
// compares every byte the FT side accepts, tracks bytes_sent against its own
// count and checks that no read is issued without room to hold it.
module tb_ft_tx_ctrl;
    import ft_pkg::*;

    localparam int ADDR_W       = 10;
    localparam int BURST_MIN    = 64;
    localparam int FLUSH_CYCLES = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bytes_sent;

    ft_tx_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ft_tx_ctrl #(
        .ADDR_W       (ADDR_W),
        .BURST_MIN    (BURST_MIN),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    // FIFO model: non-showahead, data appears the edge after the read request.
    logic [7:0]  fifo_mem [0:1023];
    int unsigned wr_ptr;
    int unsigned rd_ptr = 0;

    assign bus.fifo_rdempty = (wr_ptr == rd_ptr);
    assign bus.fifo_rdusedw = ADDR_W'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rdreq && (wr_ptr != rd_ptr)) begin
            bus.fifo_q <= fifo_mem[rd_ptr[9:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    logic [7:0]  exp_q [$];
    logic [31:0] exp_sent;
    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int          held;
    int          rd_count;
    logic        mon_acc;
    logic [7:0]  exp_byte;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int n, input logic [7:0] first);
        logic [9:0] idx;
        for (int i = 0; i < n; i++) begin
            idx           = 10'(wr_ptr) + 10'(i);
            fifo_mem[idx] = first + 8'(i);
            exp_q.push_back(first + 8'(i));
        end
        wr_ptr = wr_ptr + n;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.ft_wr_n || !bus.fifo_rdempty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        exp_sent = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: a byte is accepted at the next rising edge when wr_n and txe_n
    // are both low at the falling edge.
    initial begin
        held     = 0;
        rd_count = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                mon_acc = !bus.ft_wr_n && !bus.ft_txe_n;
                if (bus.fifo_rdreq) begin
                    n_vectors++;
                    if (held - int'(mon_acc) >= 2) begin
                        n_miscompares++;
                        $display("[TB] FAIL rdreq_room: actual held %0d acc %0d required held-acc < 2",
                                 held, mon_acc);
                    end
                    rd_count++;
                end
                if (mon_acc) begin
                    if (exp_q.size() == 0) begin
                        n_vectors++;
                        n_miscompares++;
                        $display("[TB] FAIL spurious_byte: actual 0x%0h required none", bus.ft_data);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check_output("ft_data", 32'(bus.ft_data), 32'(exp_byte));
                    end
                    check_output("bytes_sent_live", bytes_sent, exp_sent);
                    exp_sent = exp_sent + 32'd1;
                end
                held = held + int'(bus.fifo_rdreq) - int'(mon_acc);
            end
        end
    end

    initial begin
        int          cnt;
        int          run;
        int          base;
        logic [31:0] txe_pat;

        rst          = 1'b1;
        wr_ptr       = 0;
        exp_sent     = 32'd0;
        bus.ft_txe_n = 1'b1;
        txe_pat      = 32'b0110_1100_0011_1010_0000_1111_0100_1001;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_wr_n",   32'(bus.ft_wr_n),    32'd1);
        check_output("rst_siwu_n", 32'(bus.ft_siwu_n),  32'd1);
        check_output("rst_rd_n",   32'(bus.ft_rd_n),    32'd1);
        check_output("rst_oe_n",   32'(bus.ft_oe_n),    32'd1);
        check_output("rst_data",   32'(bus.ft_data),    32'd0);
        check_output("rst_rdreq",  32'(bus.fifo_rdreq), 32'd0);
        check_output("rst_sent",   bytes_sent,          32'd0);

        // Below BURST_MIN: nothing moves until the idle timeout, then one
        // SIWU# pulse after a further idle timeout.
        $display("[TB] partial burst with idle flush");
        bus.ft_txe_n = 1'b0;
        rst          = 1'b0;
        apply_stimulus(10, 8'hA0);
        cnt = 0;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            @(negedge clk);
            if (!bus.ft_wr_n) cnt++;
        end
        check_output("early_writes", 32'(cnt), 32'd0);
        wait_drain(200);
        check_output("sent_after_10", bytes_sent, 32'd10);
        cnt = 0;
        for (int i = 0; i < 3 * FLUSH_CYCLES; i++) begin
            @(negedge clk);
            if (!bus.ft_siwu_n) cnt++;
        end
        check_output("siwu_pulses", 32'(cnt), 32'd1);

        // Exactly BURST_MIN bytes: back-to-back writes.
        $display("[TB] 64-byte burst");
        pulse_reset();
        apply_stimulus(64, 8'h00);
        cnt = 0;
        while (bus.ft_wr_n && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        run = 0;
        while (!bus.ft_wr_n && run < 200) begin
            run++;
            @(negedge clk);
        end
        check_output("burst_run", 32'(run), 32'd64);
        repeat (5) @(negedge clk);
        check_output("sent_after_64", bytes_sent, 32'd64);
        check_output("state_idle", 32'(dut.state), 32'(IDLE));

        // 200 bytes with TXE# toggling.
        $display("[TB] 200 bytes with txe toggling");
        apply_stimulus(200, 8'h00);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 bus.ft_txe_n = txe_pat[5'(i)];
        end
        @(posedge clk);
        #1 bus.ft_txe_n = 1'b0;
        wait_drain(1000);
        check_output("sent_after_200", bytes_sent, 32'd264);

        // TXE# held high: first byte waits on the bus, only two reads issued.
        $display("[TB] txe held high");
        bus.ft_txe_n = 1'b1;
        base = rd_count;
        apply_stimulus(64, 8'h40);
        repeat (20) @(negedge clk);
        check_output("stall_wr_n",  32'(bus.ft_wr_n),     32'd0);
        check_output("stall_data",  32'(bus.ft_data),     32'h40);
        check_output("stall_reads", 32'(rd_count - base), 32'd2);
        @(posedge clk);
        #1 bus.ft_txe_n = 1'b0;
        wait_drain(300);
        check_output("sent_after_stall", bytes_sent, 32'd328);

        // Reset mid-stream.
        $display("[TB] reset mid-stream");
        apply_stimulus(100, 8'h10);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_output("mid_rst_wr_n",   32'(bus.ft_wr_n),    32'd1);
        check_output("mid_rst_siwu_n", 32'(bus.ft_siwu_n),  32'd1);
        check_output("mid_rst_data",   32'(bus.ft_data),    32'd0);
        check_output("mid_rst_rdreq",  32'(bus.fifo_rdreq), 32'd0);
        check_output("mid_rst_sent",   bytes_sent,          32'd0);
        exp_q.delete();
        wr_ptr   = rd_ptr;
        exp_sent = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(64, 8'hC0);
        wait_drain(300);
        check_output("sent_after_restart", bytes_sent, 32'd64);

        // Counter wrap.
        $display("[TB] bytes_sent wrap");
        @(posedge clk);
        #1 force dut.sent_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.sent_cnt;
        exp_sent = 32'hFFFF_FFFE;
        apply_stimulus(3, 8'h77);
        wait_drain(4 * FLUSH_CYCLES + 100);
        check_output("sent_wrapped", bytes_sent, 32'd1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
